seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle restoring divider that computes an unsigned quotient and remainder, with optional round-half-up, saturation and divide-by-zero reporting. It is the general successor to the fixed 10^6/period frequency divider. It sits between the period-measurement counter and the BCD display converter, and accepts any dividend, so the same block serves frequency, duty and scaling computations. A start/busy/done handshake replaces the old enable/enbcd pair.

## Interface
- NUM_W, 20: dividend width in bits; also the number of iteration cycles.
- DEN_W, 14: divisor width in bits; also the remainder width.
- Q_W, 9: output quotient width. Results that exceed Q_W bits saturate.
- ROUND, 1: 1 = round half up; 0 = truncate.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a division. Sampled only in IDLE.
- dividend  in  NUM_W  unsigned dividend, latched on an accepted start.
- divisor  in  DEN_W  unsigned divisor, latched on an accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- quotient  out  Q_W  rounded/saturated quotient.
- remainder  out  DEN_W  true remainder, taken before rounding.
- div_by_zero  out  1  the last result had divisor == 0.
- overflow  out  1  the last result saturated.

## Operation
- States: IDLE, CALC, FINISH.
- **IDLE**
  - If start=1: latch the operands.
  - If divisor==0: go to FINISH with the zero flag set.
  - Otherwise: clear the partial remainder (DEN_W+1 bits), load the quotient shift register with the dividend, set cnt=NUM_W-1, and go to CALC.
- **CALC**, one bit per cycle:
  - Shift {P,Q} left by 1.
  - If the shifted P >= divisor: subtract divisor from P and set the new Q LSB to 1.
  - Leave CALC when cnt==0; otherwise decrement cnt.
- **FINISH**
  - q_full = Q (NUM_W+1 bits).
  - If ROUND=1 and 2*P >= divisor: q_full = Q+1.
  - If q_full > 2^Q_W-1: quotient = all ones and overflow=1. Otherwise quotient = q_full[Q_W-1:0] and overflow=0.
  - remainder = P[DEN_W-1:0].
  - Zero divisor: quotient = all ones, remainder = 0, div_by_zero=1, overflow=0.
  - Register all result outputs, pulse done, return to IDLE.
- Outputs hold their values until the next FINISH.
- A start while busy is ignored; the in-flight operation is not disturbed.
- Rounding carry can cause overflow (e.g. 511 rounding up to 512 with Q_W=9); the result saturates.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state IDLE.
- Reset asserted mid-operation aborts immediately with no done pulse.
- Let E be the edge on which start is sampled in IDLE.
- Normal case:
  - busy is high from E+1 to E+NUM_W+1, i.e. NUM_W CALC cycles plus the FINISH cycle.
  - done is high for the single cycle after edge E+NUM_W+1 (22 cycles after start with the defaults).
- Divide-by-zero case: busy is high for 1 cycle (FINISH only); done follows on the next cycle.
- Back-to-back:
  - busy=0 during the done cycle, and start is accepted then.
  - Throughput is one result every NUM_W+2 cycles.
- busy and done are never high in the same cycle.

## Structure
- Package seq_divider_pkg holds:
  - state enum (IDLE, CALC, FINISH), one-hot;
  - the counter width function clog2(NUM_W);
  - default parameter constants.
- Sub-module div_step (combinational):
  - inputs: partial remainder, incoming bit, divisor;
  - outputs: next remainder and quotient bit.
- The top module holds the FSM, operand registers, and the round/saturate logic.

## Test plan
- 1000000 / 2500: quotient 400, remainder 0, overflow 0; done exactly 22 cycles after start.
- 1000000 / 2400:
  - ROUND=1: quotient 417, remainder 1600.
  - ROUND=0: quotient 416.
- 1000000 / 1000: quotient 511 (saturated), overflow=1, remainder 0. Also 1023 / 2 with ROUND=1: 511 rem 1 rounds to 512, saturates to 511, overflow=1.
- Divisor 0, dividend 12345: quotient 511, remainder 0, div_by_zero=1; done 2 cycles after start.
- Handshake and reset:
  - Assert start continuously: results complete every 22 cycles, and starts issued while busy are ignored.
  - Assert rst at cycle 10 of a division: all outputs go to 0 and no done pulse occurs.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the one-hot FSM encoding, the counter-width helper and default sizes.
package seq_divider_pkg;

  localparam int DEF_NUM_W = 20;
  localparam int DEF_DEN_W = 14;
  localparam int DEF_Q_W   = 9;
  localparam int DEF_ROUND = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    CALC   = 3'b010,
    FINISH = 3'b100
  } state_t;

  // Bits needed to count 0..v-1; never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int DEN_W = 14
) (
  input  logic [DEN_W:0]   p_in,
  input  logic             bit_in,
  input  logic [DEN_W-1:0] divisor,
  output logic [DEN_W:0]   p_out,
  output logic             q_bit
);

  logic [DEN_W:0] shifted;

  // The dropped MSB of p_in only ever means "shifted value exceeds divisor".
  always_comb begin
    shifted = {p_in[DEN_W-1:0], bit_in};
    q_bit   = p_in[DEN_W] | (shifted >= {1'b0, divisor});
    p_out   = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider with start/busy/done handshake, optional
// round-half-up, quotient saturation and divide-by-zero reporting.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W,
  parameter int Q_W   = DEF_Q_W,
  parameter int ROUND = DEF_ROUND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = clog2(NUM_W);

  state_t           state, state_nx;
  logic [DEN_W:0]   p_r, p_nx;
  logic [NUM_W-1:0] q_r;
  logic [DEN_W-1:0] dsr_r;
  logic [CNT_W-1:0] cnt;
  logic             zero_r;
  logic             q_bit;
  logic [NUM_W:0]   q_full;
  logic             round_up;
  logic             sat;

  div_step #(.DEN_W(DEN_W)) u_step (
    .p_in    (p_r),
    .bit_in  (q_r[NUM_W-1]),
    .divisor (dsr_r),
    .p_out   (p_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? FINISH : CALC;
      CALC:    if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Remainder is always < divisor here, so 2*P fits in DEN_W+1 bits plus the guard MSB.
  always_comb begin
    round_up = 1'b0;
    if (ROUND != 0)
      round_up = p_r[DEN_W] | ({p_r[DEN_W-1:0], 1'b0} >= {1'b0, dsr_r});
    q_full = {1'b0, q_r} + (NUM_W+1)'(round_up);
    sat    = |q_full[NUM_W:Q_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r         <= '0;
      q_r         <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      zero_r      <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dsr_r  <= divisor;
          zero_r <= (divisor == '0);
          p_r    <= '0;
          q_r    <= dividend;
          cnt    <= CNT_W'(NUM_W - 1);
        end
        CALC: begin
          p_r <= p_nx;
          q_r <= {q_r[NUM_W-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          if (zero_r) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= sat ? '1 : q_full[Q_W-1:0];
            remainder   <= p_r[DEN_W-1:0];
            div_by_zero <= 1'b0;
            overflow    <= sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases from the block's
// contract plus randomized operands against an arithmetic reference model.
module tb_seq_divider;

  localparam int NUM_W = 20;
  localparam int DEN_W = 14;
  localparam int Q_W   = 9;
  localparam int QMAX  = (1 << Q_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [NUM_W-1:0] dividend = '0;
  logic [DEN_W-1:0] divisor = '0;

  logic             busy, done, div_by_zero, overflow;
  logic [Q_W-1:0]   quotient;
  logic [DEN_W-1:0] remainder;
  logic             busy_t, done_t, div_by_zero_t, overflow_t;
  logic [Q_W-1:0]   quotient_t;
  logic [DEN_W-1:0] remainder_t;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W), .Q_W(Q_W), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W), .Q_W(Q_W), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_t), .done(done_t), .quotient(quotient_t), .remainder(remainder_t),
    .div_by_zero(div_by_zero_t), .overflow(overflow_t)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, then rounding and saturation rules.
  task automatic model(input longint a, input longint b, input bit rnd,
                       output longint q, output longint r, output longint dz,
                       output longint ov);
    longint qf;
    if (b == 0) begin
      q = QMAX; r = 0; dz = 1; ov = 0;
    end else begin
      qf = a / b;
      r  = a % b;
      if (rnd && (2 * r >= b)) qf = qf + 1;
      dz = 0;
      ov = (qf > QMAX) ? 1 : 0;
      q  = (qf > QMAX) ? QMAX : qf;
    end
  endtask

  task automatic run(input string tag, input longint a, input longint b);
    longint q, r, dz, ov, qt, rt, dzt, ovt;
    int n;
    bit got;
    model(a, b, 1'b1, q, r, dz, ov);
    model(a, b, 1'b0, qt, rt, dzt, ovt);
    @(negedge clk);
    dividend = NUM_W'(a);
    divisor  = DEN_W'(b);
    start    = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    chk({tag, " latency"}, n, (b == 0) ? 2 : NUM_W + 2);
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
    chk({tag, " div_by_zero"}, div_by_zero, dz);
    chk({tag, " overflow"}, overflow, ov);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " trunc_done"}, done_t, 1);
    chk({tag, " trunc_quotient"}, quotient_t, qt);
    chk({tag, " trunc_overflow"}, overflow_t, ovt);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    longint q, r, dz, ov;
    longint a, b, a2, b2;
    int n, first_n, dones, overlap;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run("1e6/2500", 1000000, 2500);
    run("1e6/2400", 1000000, 2400);
    run("1e6/1000", 1000000, 1000);
    run("1023/2", 1023, 2);
    run("12345/0", 12345, 0);
    run("0/7", 0, 7);
    run("max/1", (1 << NUM_W) - 1, 1);
    run("5/16383", 5, 16383);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range((1 << NUM_W) - 1, 0);
      case (i % 4)
        0: b = $urandom_range(16383, 1);
        1: b = $urandom_range(64, 1);
        2: b = $urandom_range(16383, 2000);
        default: b = (i == 7) ? 0 : $urandom_range(4000, 1);
      endcase
      run($sformatf("rand%0d", i), a, b);
    end

    // Held start: in-flight operands latched, later changes ignored until done
    a = 1000000; b = 2400; a2 = 777777; b2 = 3000;
    @(negedge clk);
    dividend = NUM_W'(a); divisor = DEN_W'(b); start = 1'b1;
    n = 0; first_n = 0; dones = 0; overlap = 0;
    while (dones < 2 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 5) begin
        dividend = NUM_W'(a2); divisor = DEN_W'(b2);
      end
      if (busy && done) overlap++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_n = n;
          model(a, b, 1'b1, q, r, dz, ov);
          chk("held first quotient", quotient, q);
          chk("held first remainder", remainder, r);
        end else begin
          chk("held interval", n - first_n, NUM_W + 2);
          model(a2, b2, 1'b1, q, r, dz, ov);
          chk("held second quotient", quotient, q);
          chk("held second remainder", remainder, r);
        end
      end
    end
    chk("held first latency", first_n, NUM_W + 2);
    chk("held done count", dones, 2);
    chk("busy_done_overlap", overlap, 0);
    start = 1'b0;
    repeat (NUM_W + 4) @(negedge clk);

    // Reset mid-operation
    dividend = NUM_W'(1000000); divisor = DEN_W'(2500); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    chk("abort overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("no done after abort", seen, 0);

    run("after reset", 1000000, 2500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
